// File: rtl/morph_pkg.sv
// Shared types and helpers for the binary morphology stages.
// EROSION_BORDER_ONE_EN (optional define) is consumed by erosion_win3.
package morph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } morph_state_e;

  // Window bit r*3+c: r=0 top row, c=0 left column.
  typedef logic [8:0] win3_t;

  localparam int unsigned DEF_IMG_W = 640;
  localparam int unsigned DEF_IMG_H = 480;
  localparam int unsigned FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

  function automatic logic is_border(input int unsigned row, input int unsigned col,
                                     input int unsigned img_w, input int unsigned img_h);
    return (row == 0) || (row == img_h - 1) || (col == 0) || (col == img_w - 1);
  endfunction

endpackage

// File: rtl/morph_line_buf.sv
// Two cascaded IMG_W-deep 1-bit delay lines sharing one address; taps give
// the pixel one row and two rows above the incoming one (read-before-write).
module morph_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          tap1,
  output logic          tap2
);

  logic mem1 [DEPTH];
  logic mem2 [DEPTH];

  assign tap1 = mem1[addr];
  assign tap2 = mem2[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem1[i] <= 1'b0;
        mem2[i] <= 1'b0;
      end
    end else if (en) begin
      mem1[addr] <= din;
      mem2[addr] <= tap1;
    end
  end

endmodule

// File: rtl/erosion_win3.sv
// Binary 3x3 erosion on a sop/eop/vld stream with internal line buffers and flush.
// Define EROSION_BORDER_ONE_EN to treat out-of-image neighbours as 1 instead of forcing border outputs to 0.
module erosion_win3
  import morph_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_sop,
  input  logic din_eop,
  input  logic din_vld,
  output logic dout,
  output logic dout_sop,
  output logic dout_eop,
  output logic dout_vld,
  output logic err_frame
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] W_FULL = CNT_W'(IMG_W);

  morph_state_e     state;
  logic [CNT_W-1:0] row, col, fcnt;
  win3_t            win, win_base, win_next;
  logic             ovld1, osop1, oeop1;
  logic [CNT_W-1:0] orow1, ocol1;

  logic             start, beat_en, beat_pix, last_flush, win_and;
  logic [CNT_W-1:0] brow, bcol;
  logic             tap1, tap2;

  // A sop beat is always beat 0 of a new frame, whatever state we are in.
  always_comb begin
    start      = din_vld & din_sop;
    beat_en    = start | ((state == RUN) & din_vld) | (state == FLUSH);
    beat_pix   = ((state == FLUSH) && !start) ? 1'b0 : din;
    brow       = start ? '0 : row;
    bcol       = start ? '0 : col;
    last_flush = (state == FLUSH) && !start && (fcnt == W_FULL);
  end

  morph_line_buf #(
    .DEPTH (IMG_W),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (beat_en),
    .addr  (bcol[AW-1:0]),
    .din   (beat_pix),
    .tap1  (tap1),
    .tap2  (tap2)
  );

  always_comb begin
    win_base = start ? '0 : win;
    win_next = {beat_pix, win_base[8:7], tap1, win_base[5:4], tap2, win_base[2:1]};
  end

  always_comb begin
`ifdef EROSION_BORDER_ONE_EN
    win3_t edge_mask;
    edge_mask = '0;
    if (orow1 == '0)    edge_mask = edge_mask | 9'b000_000_111;
    if (orow1 == H_LAST) edge_mask = edge_mask | 9'b111_000_000;
    if (ocol1 == '0)    edge_mask = edge_mask | 9'b001_001_001;
    if (ocol1 == W_LAST) edge_mask = edge_mask | 9'b100_100_100;
    win_and = &(win | edge_mask);
`else
    win_and = !is_border(32'(orow1), 32'(ocol1), IMG_W, IMG_H) && (&win);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      fcnt      <= '0;
      win       <= '0;
      ovld1     <= 1'b0;
      osop1     <= 1'b0;
      oeop1     <= 1'b0;
      orow1     <= '0;
      ocol1     <= '0;
      dout      <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      dout_vld  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= (start && state != IDLE) || (start && din_eop) ||
                   (state == RUN && din_vld && din_eop && !din_sop &&
                    !(row == H_LAST && col == W_LAST));

      // Beat b yields centre b-IMG_W-1: one column left, one row up.
      if (beat_en) begin
        win <= win_next;
        if (bcol == W_LAST) begin
          col <= '0;
          row <= brow + 1'b1;
        end else begin
          col <= bcol + 1'b1;
          row <= brow;
        end
        ovld1 <= (brow >= CNT_W'(2)) || (brow == CNT_W'(1) && bcol != '0);
        osop1 <= (brow == CNT_W'(1)) && (bcol == CNT_W'(1));
        oeop1 <= last_flush;
        if (bcol != '0) begin
          orow1 <= brow - 1'b1;
          ocol1 <= bcol - 1'b1;
        end else begin
          orow1 <= brow - CNT_W'(2);
          ocol1 <= W_LAST;
        end
      end else begin
        ovld1 <= 1'b0;
        osop1 <= 1'b0;
        oeop1 <= 1'b0;
      end

      if (start) begin
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (din_vld && din_eop) begin
              state <= FLUSH;
              fcnt  <= '0;
            end
          end
          FLUSH: begin
            if (last_flush) state <= IDLE;
            else            fcnt  <= fcnt + 1'b1;
          end
          default: ;
        endcase
      end

      dout_vld <= ovld1;
      dout_sop <= osop1;
      dout_eop <= oeop1;
      dout     <= ovld1 & win_and;
    end
  end

endmodule
